// File: rtl/neuron_layer_seq.sv
// Dense-layer sequencer around an external combinational Q1.6 neuron MAC.
// Build option: NEURON_RELU_EN clamps negative results to zero at the output.
module neuron_layer_seq #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    localparam int XAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int BAW  = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           w_rd,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_rdata,
    output logic           x_rd,
    output logic [XAW-1:0] x_addr,
    input  logic [DW-1:0]  x_rdata,
    output logic           b_rd,
    output logic [BAW-1:0] b_addr,
    input  logic [DW-1:0]  b_rdata,
    output logic [DW-1:0]  nrn_w,
    output logic [DW-1:0]  nrn_x,
    output logic [DW-1:0]  nrn_b,
    input  logic [DW-1:0]  nrn_out,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [DW-1:0]  y_data,
    output logic [BAW-1:0] y_idx
);

    localparam logic [XAW-1:0] ILAST = XAW'(N_IN - 1);
    localparam logic [BAW-1:0] JLAST = BAW'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        OUT,
        DONE
    } state_t;

    state_t         state;
    logic [XAW-1:0] i;
    logic [BAW-1:0] j;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  y_next;

    assign nrn_w = w_rdata;
    assign nrn_x = x_rdata;
    assign nrn_b = (i == '0) ? b_rdata : acc;

`ifdef NEURON_RELU_EN
    assign y_next = nrn_out[DW-1] ? '0 : nrn_out;
`else
    assign y_next = nrn_out;
`endif

    // Strobes are registered one step ahead: the read for term i+1
    // is in flight while term i is being accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w_rd    <= 1'b0;
            x_rd    <= 1'b0;
            b_rd    <= 1'b0;
            w_addr  <= '0;
            x_addr  <= '0;
            b_addr  <= '0;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_idx   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        b_rd   <= 1'b1;
                        w_rd   <= 1'b1;
                        x_rd   <= 1'b1;
                        b_addr <= '0;
                        w_addr <= '0;
                        x_addr <= '0;
                    end
                end
                LOAD: begin
                    state <= MAC;
                    b_rd  <= 1'b0;
                    if (ILAST != '0) begin
                        w_rd   <= 1'b1;
                        x_rd   <= 1'b1;
                        w_addr <= w_addr + WAW'(1);
                        x_addr <= x_addr + XAW'(1);
                    end else begin
                        w_rd <= 1'b0;
                        x_rd <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= nrn_out;
                    if (i == ILAST) begin
                        state   <= OUT;
                        i       <= '0;
                        w_rd    <= 1'b0;
                        x_rd    <= 1'b0;
                        y_valid <= 1'b1;
                        y_data  <= y_next;
                        y_idx   <= j;
                    end else begin
                        i <= i + XAW'(1);
                        if (i != ILAST - XAW'(1)) begin
                            w_rd   <= 1'b1;
                            x_rd   <= 1'b1;
                            w_addr <= w_addr + WAW'(1);
                            x_addr <= x_addr + XAW'(1);
                        end else begin
                            w_rd <= 1'b0;
                            x_rd <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (j == JLAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= LOAD;
                            j      <= j + BAW'(1);
                            b_rd   <= 1'b1;
                            w_rd   <= 1'b1;
                            x_rd   <= 1'b1;
                            b_addr <= j + BAW'(1);
                            w_addr <= w_addr + WAW'(1);
                            x_addr <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
